neuron_state_bank: RTL and testbench

NEURON_STATE_BANK -- requirements
Module: neuron_state_bank

---
 rtl/neuron_state_bank_if.sv | 28 ++
 rtl/neuron_state_bank.sv | 114 +++++++++++
 tb/tb_neuron_state_bank.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/neuron_state_bank_if.sv
// Request/response bundle for the neuron state bank: init control, read and write ports.
interface neuron_state_bank_if #(
    parameter int unsigned NUMWIDTH = 16,
    parameter int unsigned TAGBITS  = 6
);
    logic                init_start;
    logic                init_busy;
    logic                rd_en;
    logic [TAGBITS-1:0]  rd_tag;
    logic                wr_en;
    logic [TAGBITS-1:0]  wr_tag;
    logic [NUMWIDTH:0]   v_new;
    logic [NUMWIDTH:0]   u_new;
    logic                rd_valid;
    logic [NUMWIDTH:0]   v_out;
    logic [NUMWIDTH:0]   u_out;
    logic [TAGBITS-1:0]  out_tag;

    modport master (
        output init_start, rd_en, rd_tag, wr_en, wr_tag, v_new, u_new,
        input  init_busy, rd_valid, v_out, u_out, out_tag
    );

    modport slave (
        input  init_start, rd_en, rd_tag, wr_en, wr_tag, v_new, u_new,
        output init_busy, rd_valid, v_out, u_out, out_tag
    );
endinterface

// File: rtl/neuron_state_bank.sv
// Per-neuron {v,u} state storage with an initialisation sweep, one-cycle registered
// reads and a write-first bypass when a read and write hit the same tag.
module neuron_state_bank #(
    parameter int unsigned       NUMWIDTH = 16,
    parameter int unsigned       TAGBITS  = 6,
    parameter logic [NUMWIDTH:0] V_INIT   = 17'h1BF00,
    parameter logic [NUMWIDTH:0] U_INIT   = 17'h1F300
) (
    input  logic                 clk,
    input  logic                 asyn_reset,
    neuron_state_bank_if.slave   bus
);
    localparam int unsigned        WORDW      = NUMWIDTH + 1;
    localparam int unsigned        NUMNEURONS = 2 ** TAGBITS;
    localparam logic [TAGBITS-1:0] LAST_TAG   = TAGBITS'(NUMNEURONS - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    logic [2*WORDW-1:0] mem_q [NUMNEURONS];

    state_e              state_q,    state_d;
    logic [TAGBITS-1:0]  init_cnt_q, init_cnt_d;
    logic                init_busy_q, init_busy_d;
    logic                rd_valid_q, rd_valid_d;
    logic [WORDW-1:0]    v_out_q,    v_out_d;
    logic [WORDW-1:0]    u_out_q,    u_out_d;
    logic [TAGBITS-1:0]  out_tag_q,  out_tag_d;

    logic                mem_we_c;
    logic [TAGBITS-1:0]  mem_addr_c;
    logic [2*WORDW-1:0]  mem_wdata_c;
    logic [2*WORDW-1:0]  rd_word_c;

    // Next-state, array write port and read-result selection
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rd_valid_d  = 1'b0;
        v_out_d     = v_out_q;
        u_out_d     = u_out_q;
        out_tag_d   = out_tag_q;
        mem_we_c    = 1'b0;
        mem_addr_c  = bus.wr_tag;
        mem_wdata_c = {bus.v_new, bus.u_new};
        rd_word_c   = (bus.wr_en && (bus.wr_tag == bus.rd_tag))
                      ? {bus.v_new, bus.u_new} : mem_q[bus.rd_tag];

        case (state_q)
            ST_INIT: begin
                mem_we_c    = 1'b1;
                mem_addr_c  = init_cnt_q;
                mem_wdata_c = {V_INIT, U_INIT};
                init_cnt_d  = init_cnt_q + TAGBITS'(1);
                if (init_cnt_q == LAST_TAG) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end
            end
            ST_RUN: begin
                mem_we_c = bus.wr_en;
                if (bus.rd_en) begin
                    rd_valid_d = 1'b1;
                    v_out_d    = rd_word_c[2*WORDW-1:WORDW];
                    u_out_d    = rd_word_c[WORDW-1:0];
                    out_tag_d  = bus.rd_tag;
                end
                // Same-cycle read/write are still honoured on the way into the sweep
                if (bus.init_start) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase

        init_busy_d = (state_d == ST_INIT);
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_busy_q <= 1'b1;
            rd_valid_q  <= 1'b0;
            v_out_q     <= '0;
            u_out_q     <= '0;
            out_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_busy_q <= init_busy_d;
            rd_valid_q  <= rd_valid_d;
            v_out_q     <= v_out_d;
            u_out_q     <= u_out_d;
            out_tag_q   <= out_tag_d;
        end
    end

    // State array deliberately has no reset; the sweep defines its contents
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_addr_c] <= mem_wdata_c;
        end
    end

    assign bus.init_busy = init_busy_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.v_out     = v_out_q;
    assign bus.u_out     = u_out_q;
    assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_neuron_state_bank.sv
// Directed, table-driven bench for neuron_state_bank plus hand sequences for sweep and reset.
module tb_neuron_state_bank;
    localparam logic [16:0] VI = 17'h1BF00;
    localparam logic [16:0] UI = 17'h1F300;

    logic clk;
    logic asyn_reset;
    int   n_pass;
    int   n_total;

    neuron_state_bank_if #(.NUMWIDTH(16), .TAGBITS(6)) bus ();

    neuron_state_bank #(
        .NUMWIDTH (16),
        .TAGBITS  (6),
        .V_INIT   (VI),
        .U_INIT   (UI)
    ) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd_en;
        logic [5:0]  rd_tag;
        logic        wr_en;
        logic [5:0]  wr_tag;
        logic [16:0] v_new;
        logic [16:0] u_new;
        logic        exp_valid;
        logic [16:0] exp_v;
        logic [16:0] exp_u;
        logic [5:0]  exp_tag;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic re, logic [5:0] rt, logic we, logic [5:0] wt,
                                logic [16:0] vn, logic [16:0] un, logic ev,
                                logic [16:0] evv, logic [16:0] euu, logic [5:0] et);
        vec_t r;
        r.rd_en = re;  r.rd_tag = rt; r.wr_en = we; r.wr_tag = wt;
        r.v_new = vn;  r.u_new = un;  r.exp_valid = ev;
        r.exp_v = evv; r.exp_u = euu; r.exp_tag = et;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with init_busy high from the current sample; optionally checks reads stay idle
    task automatic count_busy(input bit check_idle, output int n);
        n = 0;
        while (bus.init_busy && n < 200) begin
            n++;
            tick();
            if (check_idle) chk("rd_valid_in_sweep", 32'(bus.rd_valid), 32'd0);
        end
    endtask

    task automatic idle_inputs();
        bus.init_start = 1'b0;
        bus.rd_en = 1'b0; bus.rd_tag = '0;
        bus.wr_en = 1'b0; bus.wr_tag = '0;
        bus.v_new = '0;   bus.u_new = '0;
    endtask

    task automatic read_chk(input string name, input logic [5:0] tag,
                            input logic [16:0] ev, input logic [16:0] eu);
        bus.rd_en = 1'b1; bus.rd_tag = tag;
        tick();
        bus.rd_en = 1'b0;
        chk({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({name, "_v"}, 32'(bus.v_out), 32'(ev));
        chk({name, "_u"}, 32'(bus.u_out), 32'(eu));
        chk({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
    endtask

    initial begin
        int nb;
        n_pass = 0;
        n_total = 0;
        idle_inputs();
        asyn_reset = 1'b1;

        vecs.push_back(mk(1, 0,  0, 0,  17'h0,     17'h0,     1, VI,        UI,        0));
        vecs.push_back(mk(1, 31, 0, 0,  17'h0,     17'h0,     1, VI,        UI,        31));
        vecs.push_back(mk(1, 63, 0, 0,  17'h0,     17'h0,     1, VI,        UI,        63));
        vecs.push_back(mk(0, 0,  1, 5,  17'h01E00, 17'h00100, 0, VI,        UI,        63));
        vecs.push_back(mk(1, 5,  0, 0,  17'h0,     17'h0,     1, 17'h01E00, 17'h00100, 5));
        vecs.push_back(mk(1, 9,  1, 9,  17'h00A00, 17'h00200, 1, 17'h00A00, 17'h00200, 9));
        vecs.push_back(mk(0, 0,  0, 0,  17'h0,     17'h0,     0, 17'h00A00, 17'h00200, 9));
        vecs.push_back(mk(1, 10, 1, 11, 17'h12345, 17'h0ABCD, 1, VI,        UI,        10));
        vecs.push_back(mk(1, 11, 0, 0,  17'h0,     17'h0,     1, 17'h12345, 17'h0ABCD, 11));
        vecs.push_back(mk(1, 9,  0, 0,  17'h0,     17'h0,     1, 17'h00A00, 17'h00200, 9));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 6'(i), 0, 0, 17'h0, 17'h0, 1,
                              (i == 5) ? 17'h01E00 : VI, (i == 5) ? 17'h00100 : UI, 6'(i)));
        vecs.push_back(mk(0, 0,  1, 3,  17'h1FFFF, 17'h10000, 0, VI,        UI,        7));
        vecs.push_back(mk(1, 3,  0, 0,  17'h0,     17'h0,     1, 17'h1FFFF, 17'h10000, 3));

        // Reset state while asyn_reset is held
        repeat (2) tick();
        chk("rst_busy",  32'(bus.init_busy), 32'd1);
        chk("rst_valid", 32'(bus.rd_valid),  32'd0);
        chk("rst_v",     32'(bus.v_out),     32'd0);
        chk("rst_u",     32'(bus.u_out),     32'd0);
        chk("rst_tag",   32'(bus.out_tag),   32'd0);

        // First sweep after release; reads requested throughout must be ignored
        asyn_reset = 1'b0;
        bus.rd_en = 1'b1; bus.rd_tag = 6'd0;
        count_busy(1'b1, nb);
        chk("sweep0_len", 32'(nb), 32'd64);
        bus.rd_en = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.rd_en  = vecs[i].rd_en;  bus.rd_tag = vecs[i].rd_tag;
            bus.wr_en  = vecs[i].wr_en;  bus.wr_tag = vecs[i].wr_tag;
            bus.v_new  = vecs[i].v_new;  bus.u_new  = vecs[i].u_new;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bus.rd_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_v", i),     32'(bus.v_out),    32'(vecs[i].exp_v));
            chk($sformatf("vec%0d_u", i),     32'(bus.u_out),    32'(vecs[i].exp_u));
            chk($sformatf("vec%0d_tag", i),   32'(bus.out_tag),  32'(vecs[i].exp_tag));
        end
        idle_inputs();

        // init_start with a same-cycle read; then reads and writes during the sweep are ignored
        bus.init_start = 1'b1;
        bus.rd_en = 1'b1; bus.rd_tag = 6'd3;
        tick();
        bus.init_start = 1'b0;
        chk("istart_valid", 32'(bus.rd_valid),  32'd1);
        chk("istart_v",     32'(bus.v_out),     32'(17'h1FFFF));
        chk("istart_busy",  32'(bus.init_busy), 32'd1);
        bus.wr_en = 1'b1; bus.wr_tag = 6'd3; bus.v_new = 17'h00000; bus.u_new = 17'h00000;
        count_busy(1'b1, nb);
        chk("sweep1_len", 32'(nb), 32'd64);
        chk("sweep1_hold_v", 32'(bus.v_out), 32'(17'h1FFFF));
        idle_inputs();
        read_chk("reinit_t3", 6'd3, VI, UI);
        read_chk("reinit_t5", 6'd5, VI, UI);

        // Reset asserted at sweep cycle 20 clears outputs at once and restarts the sweep
        bus.init_start = 1'b1;
        tick();
        bus.init_start = 1'b0;
        repeat (19) tick();
        chk("mid_busy_pre", 32'(bus.init_busy), 32'd1);
        asyn_reset = 1'b1;
        #1;
        chk("mid_rst_v",     32'(bus.v_out),     32'd0);
        chk("mid_rst_u",     32'(bus.u_out),     32'd0);
        chk("mid_rst_tag",   32'(bus.out_tag),   32'd0);
        chk("mid_rst_valid", 32'(bus.rd_valid),  32'd0);
        chk("mid_rst_busy",  32'(bus.init_busy), 32'd1);
        repeat (2) tick();
        asyn_reset = 1'b0;
        count_busy(1'b0, nb);
        chk("sweep2_len", 32'(nb), 32'd64);
        read_chk("post_rst_t63", 6'd63, VI, UI);
        read_chk("post_rst_t11", 6'd11, VI, UI);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
